// File: rtl/savestates_pkg.sv
// savestates_pkg: shared state types and constants for the savestate register sequencer.
package savestates_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_STROBE,
    ST_PUSH,
    ST_NEXT,
    ST_DONE
  } ss_seq_state_t;

  typedef enum logic {
    BUS_IDLE,
    BUS_STROBE
  } ss_bus_state_t;

  localparam logic [23:0] SS_SA1_REG_BASE = 24'h002200;
  localparam logic [7:0]  SS_IDLE_BYTE    = 8'hFF;

  // Width of the register index: at least one bit, even for a single-byte window.
  function automatic int unsigned ss_idx_width(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/savestates_bus_cycle.sv
// savestates_bus_cycle: one synthetic SNES bus cycle (SETUP/STROBE) on the
// savestate register-shadow port. Strobe falls on sysclkf_ce, rises on sysclkr_ce.
module savestates_bus_cycle
  import savestates_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic        rnw,
  input  logic [23:0] addr,
  input  logic [7:0]  wdata,
  input  logic        sysclkf_ce,
  input  logic        sysclkr_ce,
  input  logic [7:0]  ss_do,
  input  logic        ss_oe,
  output logic        cpurd_n,
  output logic        cpuwr_n,
  output logic        cpuwr_ce,
  output logic [23:0] ca,
  output logic [7:0]  di,
  output logic [7:0]  rdata,
  output logic        rmiss,
  output logic        ack
);

  ss_bus_state_t bus_state, bus_state_n;
  logic          rnw_q;
  logic          launch;

  // Bus phase register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus_state <= BUS_IDLE;
    else          bus_state <= bus_state_n;
  end

  // Launch on the falling sysclk enable; a coincident rising enable is ignored
  // because only the STROBE phase reacts to sysclkr_ce.
  always_comb begin
    bus_state_n = bus_state;
    launch      = 1'b0;
    ack         = 1'b0;
    rmiss       = 1'b0;
    case (bus_state)
      BUS_IDLE: begin
        if (go && sysclkf_ce) begin
          launch      = 1'b1;
          bus_state_n = BUS_STROBE;
        end
      end
      BUS_STROBE: begin
        if (sysclkr_ce) begin
          ack         = 1'b1;
          rmiss       = rnw_q && !ss_oe;
          bus_state_n = BUS_IDLE;
        end
      end
      default: bus_state_n = BUS_IDLE;
    endcase
  end

  // Address/data/strobe registers: held stable for the whole strobe-low window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpurd_n  <= 1'b1;
      cpuwr_n  <= 1'b1;
      cpuwr_ce <= 1'b0;
      ca       <= '0;
      di       <= '0;
      rdata    <= '0;
      rnw_q    <= 1'b1;
    end else begin
      cpuwr_ce <= 1'b0;
      if (launch) begin
        ca      <= addr;
        di      <= wdata;
        rnw_q   <= rnw;
        cpurd_n <= !rnw;
        cpuwr_n <= rnw;
      end
      if (ack) begin
        cpurd_n  <= 1'b1;
        cpuwr_n  <= 1'b1;
        cpuwr_ce <= !rnw_q;
        if (rnw_q) rdata <= ss_oe ? ss_do : SS_IDLE_BYTE;
      end
    end
  end

endmodule

// File: rtl/savestates_map_seq.sv
// savestates_map_seq: walks a contiguous register window, saving via synthetic
// reads into wr_* or loading rd_* bytes via synthetic writes.
// Optional feature macro: SS_LOAD_EN (load path); without it every start is a save.
module savestates_map_seq
  import savestates_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = SS_SA1_REG_BASE,
  parameter int unsigned REG_COUNT = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sysclkf_ce,
  input  logic        sysclkr_ce,
  input  logic        start,
  input  logic        load,
  output logic        ss_busy,
  output logic        save_en,
  output logic        ss_reg_sel,
  output logic [23:0] ca,
  output logic        cpurd_n,
  output logic        cpuwr_n,
  output logic        cpuwr_ce,
  output logic [7:0]  di,
  input  logic [7:0]  ss_do,
  input  logic        ss_oe,
  output logic [7:0]  wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  input  logic [7:0]  rd_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  output logic        done,
  output logic        miss
);

  localparam int unsigned    IW       = ss_idx_width(REG_COUNT);
  localparam logic [IW-1:0]  LAST_IDX = IW'(REG_COUNT - 1);

  ss_seq_state_t state, state_n;
  logic [IW-1:0] idx;
  logic          go, rnw, ack, rmiss;
  logic          start_load;
  logic          load_q;
  logic [7:0]    wdata;
  logic [23:0]   addr;

`ifdef SS_LOAD_EN
  logic [7:0] data_q;

  assign start_load = load;
  assign wdata      = data_q;

  // Load-mode flag and the byte fetched from the load stream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_q <= 1'b0;
      data_q <= '0;
    end else begin
      if (state == ST_IDLE && start) load_q <= load;
      if (state == ST_FETCH && rd_valid) data_q <= rd_data;
    end
  end
`else
  logic unused_load_inputs;

  assign start_load         = 1'b0;
  assign load_q             = 1'b0;
  assign wdata              = '0;
  assign unused_load_inputs = ^{load, rd_valid, rd_data};
`endif

  assign rnw  = !load_q;
  assign addr = BASE_ADDR + 24'(idx);

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n  = state;
    go       = 1'b0;
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_n = start_load ? ST_FETCH : ST_SETUP;
      end
`ifdef SS_LOAD_EN
      ST_FETCH: begin
        rd_ready = 1'b1;
        if (rd_valid) state_n = ST_SETUP;
      end
`endif
      ST_SETUP: begin
        go = 1'b1;
        if (sysclkf_ce) state_n = ST_STROBE;
      end
      ST_STROBE: begin
        if (ack) state_n = load_q ? ST_NEXT : ST_PUSH;
      end
      ST_PUSH: begin
        wr_valid = 1'b1;
        if (wr_ready) state_n = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx == LAST_IDX) state_n = ST_DONE;
        else                 state_n = load_q ? ST_FETCH : ST_SETUP;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Register index and sticky read-miss flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx  <= '0;
      miss <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        idx  <= '0;
        miss <= 1'b0;
      end
      if (rmiss) miss <= 1'b1;
      if (state == ST_NEXT && idx != LAST_IDX) idx <= idx + IW'(1);
    end
  end

  assign ss_busy    = (state != ST_IDLE);
  assign save_en    = ss_busy && !load_q;
  assign ss_reg_sel = (state == ST_SETUP) || (state == ST_STROBE);

  savestates_bus_cycle u_bus (
    .clk        (clk),
    .reset_n    (reset_n),
    .go         (go),
    .rnw        (rnw),
    .addr       (addr),
    .wdata      (wdata),
    .sysclkf_ce (sysclkf_ce),
    .sysclkr_ce (sysclkr_ce),
    .ss_do      (ss_do),
    .ss_oe      (ss_oe),
    .cpurd_n    (cpurd_n),
    .cpuwr_n    (cpuwr_n),
    .cpuwr_ce   (cpuwr_ce),
    .ca         (ca),
    .di         (di),
    .rdata      (wr_data),
    .rmiss      (rmiss),
    .ack        (ack)
  );

endmodule

// File: tb/tb_savestates_map_seq.sv
// tb_savestates_map_seq: directed bench for the savestate register sequencer.
module tb_savestates_map_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sysclkf_ce = 1'b0, sysclkr_ce = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, load = 1'b0;
  logic wr_ready = 1'b1;
  logic [7:0] rd_data = '0;
  logic rd_valid = 1'b0;
  logic miss_mode = 1'b0;
  logic [7:0] ss_do;
  logic ss_oe;

  logic ss_busy_a, save_en_a, ss_reg_sel_a, cpurd_n_a, cpuwr_n_a, cpuwr_ce_a;
  logic wr_valid_a, rd_ready_a, done_a, miss_a;
  logic [23:0] ca_a;
  logic [7:0] di_a, wr_data_a;
  logic ss_busy_b, save_en_b, ss_reg_sel_b, cpurd_n_b, cpuwr_n_b, cpuwr_ce_b;
  logic wr_valid_b, rd_ready_b, done_b, miss_b;
  logic [23:0] ca_b;
  logic [7:0] di_b, wr_data_b;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  // Bus environment: readback is idx^5A, with an optional dropout on register 2.
  assign ss_do = ca_a[7:0] ^ 8'h5A;
  assign ss_oe = !(miss_mode && ca_a[7:0] == 8'h02);

  // sysclk enables: falling on phase 0, rising on phase 3 of a 6-clk period.
  int unsigned ce_cnt = 0;
  always @(posedge clk) begin
    #1;
    ce_cnt = (ce_cnt == 5) ? 0 : ce_cnt + 1;
    sysclkf_ce = (ce_cnt == 0);
    sysclkr_ce = (ce_cnt == 3);
  end

  savestates_map_seq #(.BASE_ADDR(24'h002200), .REG_COUNT(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .sysclkf_ce(sysclkf_ce), .sysclkr_ce(sysclkr_ce),
    .start(start_a), .load(load), .ss_busy(ss_busy_a), .save_en(save_en_a),
    .ss_reg_sel(ss_reg_sel_a), .ca(ca_a), .cpurd_n(cpurd_n_a), .cpuwr_n(cpuwr_n_a),
    .cpuwr_ce(cpuwr_ce_a), .di(di_a), .ss_do(ss_do), .ss_oe(ss_oe),
    .wr_data(wr_data_a), .wr_valid(wr_valid_a), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready_a),
    .done(done_a), .miss(miss_a)
  );

  savestates_map_seq #(.BASE_ADDR(24'hFFFFFE), .REG_COUNT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .sysclkf_ce(sysclkf_ce), .sysclkr_ce(sysclkr_ce),
    .start(start_b), .load(1'b0), .ss_busy(ss_busy_b), .save_en(save_en_b),
    .ss_reg_sel(ss_reg_sel_b), .ca(ca_b), .cpurd_n(cpurd_n_b), .cpuwr_n(cpuwr_n_b),
    .cpuwr_ce(cpuwr_ce_b), .di(di_b), .ss_do(ss_do), .ss_oe(ss_oe),
    .wr_data(wr_data_b), .wr_valid(wr_valid_b), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready_b),
    .done(done_b), .miss(miss_b)
  );

  // Monitors: stream handshakes, write pulses, bus-cycle starts, done pulses.
  logic [31:0] hs_q[$];
  logic [31:0] wr_q[$];
  logic [23:0] addr_b_q[$];
  int bus_cnt_a = 0, done_cnt_a = 0, done_cnt_b = 0, overlap_cnt = 0;
  logic prev_rd_a = 1'b1, prev_wr_a = 1'b1, prev_rd_b = 1'b1;

  always @(negedge clk) begin
    if (wr_valid_a && wr_ready) hs_q.push_back({ca_a, wr_data_a});
    if (cpuwr_ce_a) wr_q.push_back({ca_a, di_a});
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if ((prev_rd_a && !cpurd_n_a) || (prev_wr_a && !cpuwr_n_a)) bus_cnt_a++;
    if (prev_rd_b && !cpurd_n_b) addr_b_q.push_back(ca_b);
    if ((!cpurd_n_a && !cpuwr_n_a) || (!cpurd_n_b && !cpuwr_n_b)) overlap_cnt++;
    prev_rd_a = cpurd_n_a;
    prev_wr_a = cpuwr_n_a;
    prev_rd_b = cpurd_n_b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start_a(input logic ld);
    @(posedge clk); #1;
    load = ld;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    load = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(input int unsigned budget);
    int unsigned k = 0;
    logic seen = 1'b0;
    while (!seen && k < budget) begin
      @(negedge clk);
      k++;
      if (done_a) seen = 1'b1;
    end
    check("done_a_seen", seen, 1);
    check("busy_at_done", ss_busy_a, 1);
    @(negedge clk);
    check("busy_fall", ss_busy_a, 0);
    check("done_one_clk", done_a, 0);
  endtask

  task automatic wait_strobe_a(input string tag);
    int unsigned k = 0;
    while (cpurd_n_a && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(tag, cpurd_n_a, 0);
  endtask

  task automatic check_save_stream(input logic [7:0] b2);
    logic [31:0] exp;
    check("save_count", hs_q.size(), 4);
    for (int i = 0; i < 4 && i < hs_q.size(); i++) begin
      exp = {24'h002200 + 24'(i), 8'(i) ^ 8'h5A};
      if (i == 2) exp[7:0] = b2;
      check("save_byte", hs_q[i], exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic stable;
    int unsigned k;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_strobes", {cpurd_n_a, cpuwr_n_a, cpuwr_ce_a}, 3'b110);
    check("rst_ca", ca_a, 24'h0);
    check("rst_di", di_a, 8'h0);
    check("rst_outs", {ss_busy_a, save_en_a, ss_reg_sel_a, wr_valid_a, rd_ready_a, done_a, miss_a}, 7'b0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Plain save of four registers.
    hs_q.delete(); done_cnt_a = 0;
    pulse_start_a(1'b0);
    check("busy_rise", ss_busy_a, 1);
    check("save_en", save_en_a, 1);
    wait_done_a(200);
    check_save_stream(8'h58);
    check("save_done_cnt", done_cnt_a, 1);
    check("save_miss", miss_a, 0);

    // Save with readback dropout on register 2.
    hs_q.delete(); miss_mode = 1'b1;
    pulse_start_a(1'b0);
    wait_done_a(200);
    check_save_stream(8'hFF);
    repeat (10) @(negedge clk);
    check("miss_sticky", miss_a, 1);
    miss_mode = 1'b0;
    pulse_start_a(1'b0);
    check("miss_clear", miss_a, 0);
    wait_done_a(200);

    // Stream backpressure in PUSH.
    hs_q.delete(); bus_cnt_a = 0; wr_ready = 1'b0;
    pulse_start_a(1'b0);
    k = 0;
    while (!wr_valid_a && k < 100) begin @(negedge clk); k++; end
    check("stall_reach", wr_valid_a, 1);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!wr_valid_a || wr_data_a !== 8'h5A || ca_a !== 24'h002200) stable = 1'b0;
    end
    check("stall_stable", stable, 1);
    check("stall_nobus", bus_cnt_a, 1);
    @(posedge clk); #1 wr_ready = 1'b1;
    wait_done_a(200);
    check_save_stream(8'h58);

`ifdef SS_LOAD_EN
    // Load with gapped input beats.
    begin
      logic [7:0] ld_bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      wr_q.delete(); bus_cnt_a = 0; rd_valid = 1'b0;
      pulse_start_a(1'b1);
      check("load_save_en", save_en_a, 0);
      for (int b = 0; b < 4; b++) begin
        k = 0;
        while (!rd_ready_a && k < 100) begin @(negedge clk); k++; end
        check("load_fetch", rd_ready_a, 1);
        stable = 1'b1;
        repeat (5) begin
          @(negedge clk);
          if (!cpurd_n_a || !cpuwr_n_a || !rd_ready_a) stable = 1'b0;
        end
        check("load_gap_quiet", stable, 1);
        check("load_gap_bus", bus_cnt_a, b);
        @(posedge clk); #1;
        rd_valid = 1'b1;
        rd_data = ld_bytes[b];
        @(posedge clk); #1;
        rd_valid = 1'b0;
        rd_data = 8'h00;
        check("rd_ready_drop", rd_ready_a, 0);
      end
      wait_done_a(200);
      check("load_count", wr_q.size(), 4);
      for (int i = 0; i < 4 && i < wr_q.size(); i++)
        check("load_write", wr_q[i], {24'h002200 + 24'(i), ld_bytes[i]});
    end
`else
    // Without the load path a load request runs as a save.
    hs_q.delete(); wr_q.delete();
    pulse_start_a(1'b1);
    check("noload_save_en", save_en_a, 1);
    check("noload_rd_ready", rd_ready_a, 0);
    wait_done_a(200);
    check_save_stream(8'h58);
    check("noload_writes", wr_q.size(), 0);
    check("noload_wr_n", cpuwr_n_a, 1);
`endif

    // Reset in the middle of a strobe.
    hs_q.delete(); done_cnt_a = 0;
    pulse_start_a(1'b0);
    wait_strobe_a("mid_strobe_reach");
    check("reg_sel_strobe", ss_reg_sel_a, 1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_strobes", {cpurd_n_a, cpuwr_n_a}, 2'b11);
    check("mid_rst_busy", ss_busy_a, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_rst_no_done", done_cnt_a, 0);
    hs_q.delete();
    pulse_start_a(1'b0);
    wait_strobe_a("restart_strobe");
    check("restart_ca", ca_a, 24'h002200);
    wait_done_a(200);
    check_save_stream(8'h58);

    // Address wrap and start-while-busy on the second instance.
    addr_b_q.delete(); done_cnt_b = 0;
    pulse_start_b();
    k = 0;
    while (cpurd_n_b && k < 100) begin @(negedge clk); k++; end
    check("wrap_first_strobe", cpurd_n_b, 0);
    pulse_start_b();
    k = 0;
    while (ss_busy_b && k < 200) begin @(negedge clk); k++; end
    check("wrap_finish", ss_busy_b, 0);
    repeat (30) @(negedge clk);
    check("wrap_count", addr_b_q.size(), 3);
    if (addr_b_q.size() >= 3) begin
      check("wrap_addr0", addr_b_q[0], 24'hFFFFFE);
      check("wrap_addr1", addr_b_q[1], 24'hFFFFFF);
      check("wrap_addr2", addr_b_q[2], 24'h000000);
    end
    check("wrap_done_cnt", done_cnt_b, 1);
    check("wrap_idle", ss_busy_b, 0);

    check("strobe_overlap", overlap_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
